// File: rtl/bus_stall_injector.sv
// Per-channel bus wait-state injector: zero, fixed or LFSR-random stalls per request.
// Define BUS_STALL_INJECTOR_CHECK_EN to build the address/request-stability checker and sticky err flags.
module bus_stall_injector_ch #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter int          WAIT_W = 3,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [1:0]        cfg_mode,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic [DATA_W-1:0] s_rddata,
  input  logic              err_clr,
  output logic              m_stall,
  output logic              s_write,
  output logic [DATA_W-1:0] m_rddata,
  output logic              err
);
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt, n;
  logic [15:0]       lfsr;
  logic              req, wr_q, accept, done, is_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    n = '0;
    case (cfg_mode)
      2'd1:    n = cfg_wait;
      2'd2:    n = lfsr[WAIT_W-1:0] & cfg_wait;
      default: n = '0;
    endcase
  end

  assign req    = m_read | m_write;
  assign accept = (state == ST_IDLE) && req && (n != '0);
  assign done   = ((state == ST_IDLE) && req && (n == '0)) || ((state == ST_WAIT) && (cnt == '0));
  // Zero-wait accepts take the live strobe; waited ones use the type latched at accept.
  assign is_wr  = (state == ST_IDLE) ? m_write : wr_q;

  assign m_stall = rst_n & (accept || ((state == ST_WAIT) && (cnt != '0)));
  assign s_write = rst_n & done & is_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      m_rddata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= ST_WAIT;
          cnt   <= n - WAIT_W'(1);
          wr_q  <= m_write;
        end
        default: if (cnt == '0) state <= ST_IDLE;
                 else           cnt   <= cnt - WAIT_W'(1);
      endcase
      if (done && !is_wr) m_rddata <= s_rddata;
    end
  end

`ifdef BUS_STALL_INJECTOR_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              viol;

  assign viol = (state == ST_WAIT) && (!req || (m_addr != addr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) addr_q <= m_addr;
      if (viol)         err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{m_addr, err_clr};
  assign err        = 1'b0;
`endif
endmodule

module bus_stall_injector #(
  parameter int          NUM_CH    = 2,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          WAIT_W    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        m_read,
  input  logic [NUM_CH-1:0]        m_write,
  input  logic [NUM_CH*ADDR_W-1:0] m_addr,
  output logic [NUM_CH-1:0]        m_stall,
  output logic [NUM_CH*DATA_W-1:0] m_rddata,
  input  logic [NUM_CH*DATA_W-1:0] s_rddata,
  output logic [NUM_CH-1:0]        s_write,
  input  logic [NUM_CH*2-1:0]      cfg_mode,
  input  logic [NUM_CH*WAIT_W-1:0] cfg_wait,
  output logic [NUM_CH-1:0]        err,
  input  logic [NUM_CH-1:0]        err_clr
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bus_stall_injector_ch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WAIT_W (WAIT_W),
      .SEED   (16'(LFSR_SEED + c))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_read   (m_read[c]),
      .m_write  (m_write[c]),
      .m_addr   (m_addr[c*ADDR_W +: ADDR_W]),
      .cfg_mode (cfg_mode[c*2 +: 2]),
      .cfg_wait (cfg_wait[c*WAIT_W +: WAIT_W]),
      .s_rddata (s_rddata[c*DATA_W +: DATA_W]),
      .err_clr  (err_clr[c]),
      .m_stall  (m_stall[c]),
      .s_write  (s_write[c]),
      .m_rddata (m_rddata[c*DATA_W +: DATA_W]),
      .err      (err[c])
    );
  end
endmodule

// File: tb/tb_bus_stall_injector.sv
// Directed bench for bus_stall_injector: zero/fixed/random waits, reset abort, checker flags.
module tb_bus_stall_injector;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_read, m_write, m_stall, s_write, err, err_clr;
  logic [63:0] m_addr, m_rddata, s_rddata;
  logic [3:0]  cfg_mode;
  logic [5:0]  cfg_wait;

  int checks = 0;
  int errors = 0;
  int cyc, done0, done1, c0, c1, exp0;
  bit start0, start1;
  logic [15:0] lf0;

`ifdef BUS_STALL_INJECTOR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  bus_stall_injector dut (
    .clk(clk), .rst_n(rst_n), .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_stall(m_stall), .m_rddata(m_rddata), .s_rddata(s_rddata), .s_write(s_write),
    .cfg_mode(cfg_mode), .cfg_wait(cfg_wait), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference channel-0 LFSR: seed 0xACE1, taps 16,14,13,11, steps every unreset cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lf0 <= 16'hACE1;
    else        lf0 <= {lf0[14:0], lf0[15] ^ lf0[13] ^ lf0[12] ^ lf0[10]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; m_read = '0; m_write = '0; m_addr = '0; s_rddata = '0;
    cfg_mode = '0; cfg_wait = '0; err_clr = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_stall", 64'(m_stall), 0);
    chk("rst_swrite", 64'(s_write), 0);
    chk("rst_rddata", m_rddata, 0);
    chk("rst_err", 64'(err), 0);
    @(negedge clk); rst_n = 1'b1;

    // Mode 0 read: zero wait, data one cycle later
    @(negedge clk);
    m_read = 2'b01; m_addr = {32'h0, 32'h8000_0000}; s_rddata = {32'h0, 32'h1234_5678};
    #1 chk("m0_stall", 64'(m_stall), 0);
    @(negedge clk); m_read = '0; s_rddata = '0;
    #1 chk("m0_rddata", m_rddata[31:0], 64'h1234_5678);
    chk("m0_stall_after", 64'(m_stall), 0);

    // Mode 1, wait 3 write: three stalls then one s_write pulse
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cfg_mode = {2'd0, 2'd1}; cfg_wait = {3'd0, 3'd3}; m_write = 2'b01; m_addr = {32'h0, 32'h40};
      #1 chk("m1_stall", 64'(m_stall[0]), 64'(i < 3));
      chk("m1_swrite", 64'(s_write[0]), 64'(i == 3));
    end
    @(negedge clk); m_write = '0;
    #1 chk("m1_swrite_off", 64'(s_write), 0);
    chk("m1_rddata_hold", m_rddata[31:0], 64'h1234_5678);

    // Mode 2 mask 7 on ch0 vs LFSR model; ch1 mode 1 wait 2; back-to-back reads
    start0 = 1; start1 = 1; done0 = 0; done1 = 0; cyc = 0; c0 = 0; c1 = 0; exp0 = 0;
    while (done0 < 1000 && cyc < 20000) begin
      @(negedge clk);
      cfg_mode = {2'd1, 2'd2}; cfg_wait = {3'd2, 3'd7}; m_read = 2'b11;
      s_rddata = {32'hCAFE_F00D, 32'h0};
      #1 cyc++;
      if (start0) begin exp0 = int'(lf0[2:0]); c0 = 0; start0 = 0; end
      if (m_stall[0]) c0++;
      else begin chk("m2_len", 64'(c0), 64'(exp0)); done0++; start0 = 1; end
      if (start1) begin c1 = 0; start1 = 0; end
      if (m_stall[1]) c1++;
      else begin chk("ch1_len", 64'(c1), 2); done1++; start1 = 1; end
    end
    chk("m2_count", 64'(done0), 1000);
    @(negedge clk); m_read = '0;
    @(negedge clk); @(negedge clk); @(negedge clk); err_clr = 2'b11;
    @(negedge clk); err_clr = '0;
    #1 chk("ch1_rddata", m_rddata[63:32], 64'hCAFE_F00D);
    chk("err_pre", 64'(err), 0);

    // Address changed mid-wait (mode 1, wait 4)
    @(negedge clk);
    cfg_mode = {2'd0, 2'd1}; cfg_wait = {3'd0, 3'd4}; m_read = 2'b01; m_addr = {32'h0, 32'h100};
    #1 chk("a_stall0", 64'(m_stall[0]), 1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); m_addr = {32'h0, 32'h104};
      #1 chk("a_stall", 64'(m_stall[0]), 64'(i < 4));
    end
    @(negedge clk); m_read = '0;
    #1 chk("a_err0", 64'(err[0]), 64'(CHK));
    chk("a_err1", 64'(err[1]), 0);
    @(negedge clk); @(negedge clk);
    #1 chk("a_err0_sticky", 64'(err[0]), 64'(CHK));
    @(negedge clk); err_clr = 2'b01;
    #1 chk("a_err0_preclr", 64'(err[0]), 64'(CHK));
    @(negedge clk); err_clr = '0;
    #1 chk("a_err0_clr", 64'(err[0]), 0);
    chk("a_err1_clr", 64'(err[1]), 0);

    // Request dropped in WAIT still completes with the accepted write
    @(negedge clk);
    cfg_wait = {3'd0, 3'd2}; m_write = 2'b01; m_addr = {32'h0, 32'h200};
    #1 chk("d_stall0", 64'(m_stall[0]), 1);
    chk("d_sw0", 64'(s_write[0]), 0);
    @(negedge clk); m_write = '0;
    #1 chk("d_stall1", 64'(m_stall[0]), 1);
    chk("d_sw1", 64'(s_write[0]), 0);
    @(negedge clk);
    #1 chk("d_stall2", 64'(m_stall[0]), 0);
    chk("d_sw2", 64'(s_write[0]), 1);
    @(negedge clk);
    #1 chk("d_sw3", 64'(s_write), 0);

    // Reset at the second stall cycle of a 5-cycle write wait
    @(negedge clk);
    cfg_wait = {3'd0, 3'd5}; m_write = 2'b01; m_addr = {32'h0, 32'h300};
    #1 chk("r_stall0", 64'(m_stall[0]), 1);
    @(negedge clk);
    #1 chk("r_stall1", 64'(m_stall[0]), 1);
    rst_n = 1'b0;
    #1 chk("r_stall_rst", 64'(m_stall), 0);
    chk("r_sw_rst", 64'(s_write), 0);
    chk("r_rddata_rst", m_rddata, 0);
    chk("r_err_rst", 64'(err), 0);
    @(negedge clk); m_write = '0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("r_sw_idle", 64'(s_write), 0);
      chk("r_stall_idle", 64'(m_stall), 0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); m_write = 2'b01;
      #1 chk("r_fresh_stall", 64'(m_stall[0]), 64'(i < 5));
      chk("r_fresh_sw", 64'(s_write[0]), 64'(i == 5));
    end
    @(negedge clk); m_write = '0;
    #1 chk("r_end_sw", 64'(s_write), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
